// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//   Hazard sequencer for the 5-stage 16-bit pipeline. It detects load-use and
//   branch-operand hazards in decode, stalls the front end (PC hold,
//   FetchDecode hold, Decode/Execute bubble) and flushes FetchDecode on a
//   taken branch. It also produces the execute-stage ALU forwarding selects
//   and keeps saturating stall/flush counters for performance debug.
//
// Ports
//   clk                        system clock, rising edge
//   reset                      asynchronous active-low reset
//   dec_valid                  decode stage holds a real instruction
//   dec_rs1/dec_rs2            decode source registers
//   dec_uses_rs1/dec_uses_rs2  decode instruction reads that source
//   dec_is_branch              decode instruction is a conditional branch
//   branch_taken               decode comparator result
//   ex_rs1/ex_rs2/ex_rd        execute source/destination registers
//   ex_we/ex_is_load           execute write-enable / load flag
//   mem_rd/mem_we/mem_is_load  memory-stage destination, write-enable, load
//   wb_rd/wb_we                writeback destination and write-enable
//   halt_req                   freeze the front end
//   pc_hold/fd_hold            PC / FetchDecode register keep their value
//   fd_flush                   FetchDecode loads a nop
//   de_bubble                  zero control signals into Decode/Execute
//   pc_sel                     1 = branch target, 0 = PC+1
//   fwd_a/fwd_b                00 regfile, 01 memory ALU result, 10 wb data
//   halted                     FSM is in HALT
//   stall_count/flush_count    saturating performance counters
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int REG_W             = 4,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_uses_rs1,
  input  logic             dec_uses_rs2,
  input  logic             dec_is_branch,
  input  logic             branch_taken,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_we,
  input  logic             mem_is_load,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_we,
  input  logic             halt_req,
  output logic             pc_hold,
  output logic             fd_hold,
  output logic             fd_flush,
  output logic             de_bubble,
  output logic             pc_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    HALT       = 2'd2
  } state_t;

  // Remaining stall cycles after the first one, which is spent in RUN.
  localparam logic [3:0] LS_INIT = 4'(LOAD_STALL_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_next;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  logic             w_match_ex;
  logic             w_match_mem;
  logic             w_load_use;
  logic             w_br_dep;
  logic             w_br_taken;
  logic             w_hold;
  logic             w_flush;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // Decode source-register matches against the execute and memory
  // destinations; dec_valid gates every detection so bubbles never stall.
  assign w_match_ex  = dec_valid &
                       ((dec_uses_rs1 & (dec_rs1 == ex_rd)) |
                        (dec_uses_rs2 & (dec_rs2 == ex_rd)));
  assign w_match_mem = dec_valid &
                       ((dec_uses_rs1 & (dec_rs1 == mem_rd)) |
                        (dec_uses_rs2 & (dec_rs2 == mem_rd)));

  assign w_load_use = ex_is_load & ex_we & w_match_ex;

  // The branch comparator sits in decode, so it needs operands that cannot
  // be forwarded in time: any execute result or a load still in memory.
  assign w_br_dep   = dec_valid & dec_is_branch &
                      ((ex_we & w_match_ex) |
                       (mem_is_load & mem_we & w_match_mem));
  assign w_br_taken = dec_valid & dec_is_branch & branch_taken;

  // Next-state and front-end control. Control is decided in the same cycle
  // the hazard is seen, so it is a Mealy function of state and detection.
  // A flush is only ever produced when no hold is active.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hold       = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      RUN: begin
        if (halt_req) begin
          w_hold       = 1'b1;
          w_state_next = HALT;
        end else if (w_load_use) begin
          w_hold = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_cnt_next   = LS_INIT;
            w_state_next = LOAD_STALL;
          end
        end else if (w_br_dep) begin
          w_hold = 1'b1;
        end else if (w_br_taken) begin
          w_flush = 1'b1;
        end
      end
      LOAD_STALL: begin
        w_hold = 1'b1;
        if (halt_req) begin
          w_cnt_next   = 4'd0;
          w_state_next = HALT;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_state_next = RUN;
          end
        end
      end
      HALT: begin
        w_hold = 1'b1;
        if (!halt_req) begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // Forwarding for the execute stage. A load in memory has no ALU result
  // to forward yet, so only non-load memory-stage writers qualify.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (mem_we & ~mem_is_load & (mem_rd == ex_rs1)) begin
      w_fwd_a = 2'b01;
    end else if (wb_we & (wb_rd == ex_rs1)) begin
      w_fwd_a = 2'b10;
    end
    if (mem_we & ~mem_is_load & (mem_rd == ex_rs2)) begin
      w_fwd_b = 2'b01;
    end else if (wb_we & (wb_rd == ex_rs2)) begin
      w_fwd_b = 2'b10;
    end
  end

  // State, stall counter and saturating performance counters. Stalls spent
  // in HALT are not hazard stalls and are excluded from stall_count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= RUN;
      r_cnt         <= 4'd0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_hold && (r_state != HALT) && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_flush && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  // Outputs are gated by the reset pin so an asserted reset drops them
  // immediately, even mid-stall, without waiting for a clock edge.
  assign pc_hold     = reset & w_hold;
  assign fd_hold     = reset & w_hold;
  assign de_bubble   = reset & w_hold;
  assign fd_flush    = reset & w_flush;
  assign pc_sel      = reset & w_flush;
  assign halted      = reset & (r_state == HALT);
  assign fwd_a       = reset ? w_fwd_a : 2'b00;
  assign fwd_b       = reset ? w_fwd_b : 2'b00;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule
